// File: rtl/ex_div_if.sv
// Execute-stage <-> divider handshake: operands and request in, {rem, quo} and ready out.
interface ex_div_if #(parameter int DATA_W = 32);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock on operand
// magnitudes, signs restored when the result is finalized.
module ex_div #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int WR_W  = 2 * DATA_W + 1;

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WR_W-1:0]       work_q, work_d;
  logic [DATA_W-1:0]     dsor_q, dsor_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     abs1, abs2;
  logic [WR_W-1:0]       shifted;
  logic [DATA_W+1:0]     trial;
  logic                  borrow;
  logic [DATA_W-1:0]     quo, rem, quo_fin, rem_fin;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign abs1    = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2    = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

  assign shifted = {work_q[WR_W-2:0], 1'b0};
  assign trial   = {1'b0, shifted[WR_W-1:DATA_W]} - {2'b0, dsor_q};
  assign borrow  = trial[DATA_W+1];

  // Partial remainder lives in [2W:W]; its top bit is always 0 once done since rem < divisor.
  assign quo     = work_q[DATA_W-1:0];
  assign rem     = work_q[2*DATA_W-1:DATA_W];
  assign quo_fin = negq_q ? -quo : quo;
  assign rem_fin = negr_q ? -rem : rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dsor_d   = dsor_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      DivFree: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            cnt_d   = '0;
            dsor_d  = abs2;
            negq_d  = op1_neg ^ op2_neg;
            negr_d  = op1_neg;
            work_d  = {{(DATA_W+1){1'b0}}, abs1};
          end
        end
      end
      DivByZero: begin
        if (bus.annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          work_d = borrow ? shifted : {trial[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
          cnt_d  = cnt_q + 1'b1;
        end else begin
          state_d  = DivEnd;
          cnt_d    = '0;
          result_d = {rem_fin, quo_fin};
          ready_d  = 1'b1;
        end
      end
      DivEnd: begin
        // Result is held for the execute stage until it drops the request.
        if (!bus.start_i) begin
          state_d  = DivFree;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      work_q   <= '0;
      dsor_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dsor_q   <= dsor_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_ex_div.sv
// Directed and randomized checks of ex_div against an arithmetic division model.
module tb_ex_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ex_div_if #(.DATA_W(32)) bus ();

  ex_div #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // DIV/DIVU semantics in 64-bit arithmetic: truncating quotient, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready_o; lat is the number of edges after acceptance, 0 if the bound expired.
  task automatic wait_ready(input int drop_at, output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == drop_at) bus.start_i = 1'b0;
      if (bus.ready_o === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int drop_at, input string tag);
    logic [63:0] exp_res;
    int lat;
    exp_res = ref_div(sgn, a, b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    tick();
    wait_ready(drop_at, lat);
    chk({tag, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
    chk({tag, "_res"}, bus.result_o, exp_res);
    if (drop_at == 0) begin
      tick();
      chk({tag, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
      chk({tag, "_hold_res"}, bus.result_o, exp_res);
      bus.start_i = 1'b0;
    end
    tick();
    chk({tag, "_rel_rdy"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_rel_res"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int lat, highs, sel;
    logic sgn;
    logic [31:0] a, b;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #12;
    chk("reset_rdy", 64'(bus.ready_o), 64'd0);
    chk("reset_res", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    chk("divu_100_7_const", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 0, "div_m7_2");
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, 0, "div_7_m2");
    run_div(1'b0, 32'h1234, 32'h0, 0, "div_by_zero");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "signed_ovf");
    run_div(1'b0, 32'h0, 32'h5, 0, "zero_dividend");

    // Annul mid-iteration: no result may appear.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFFFFFF;
    bus.opdata2_i    = 32'h3;
    bus.start_i      = 1'b1;
    tick();
    repeat (10) tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    highs = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.ready_o === 1'b1) highs++;
      tick();
    end
    chk("annul_no_ready", 64'(highs), 64'd0);
    run_div(1'b0, 32'hFFFFFFFF, 32'h3, 0, "after_annul");

    // Annul while in the divide-by-zero state.
    bus.opdata1_i = 32'h5;
    bus.opdata2_i = 32'h0;
    bus.start_i   = 1'b1;
    tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    highs = 0;
    for (int n = 0; n < 5; n++) begin
      if (bus.ready_o === 1'b1) highs++;
      tick();
    end
    chk("annul_dbz_no_ready", 64'(highs), 64'd0);

    // Async reset while holding a finished result.
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    tick();
    wait_ready(0, lat);
    chk("rst_end_pre_rdy", 64'(bus.ready_o), 64'd1);
    #2 rst = 1'b1;
    bus.start_i = 1'b0;
    #1;
    chk("rst_end_rdy", 64'(bus.ready_o), 64'd0);
    chk("rst_end_res", bus.result_o, 64'd0);
    #1 rst = 1'b0;
    tick();

    // Async reset mid-operation.
    bus.opdata1_i = 32'hFFFFFFFF;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    tick();
    repeat (20) tick();
    #2 rst = 1'b1;
    bus.start_i = 1'b0;
    #1;
    chk("rst_mid_rdy", 64'(bus.ready_o), 64'd0);
    chk("rst_mid_res", bus.result_o, 64'd0);
    #1 rst = 1'b0;
    highs = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.ready_o === 1'b1) highs++;
    end
    chk("rst_mid_no_ready", 64'(highs), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 0, "after_rst");

    // Request dropped during iteration still completes, ready pulses once.
    run_div(1'b1, 32'hFFFF_FF00, 32'd13, 5, "start_drop");

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      a   = $urandom;
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       begin a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF; b = $urandom; end
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, 0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
